// File: rtl/tt_lockstep_checker.sv
// Lockstep comparator for replicated TinyTapeout design instances.
// Counts divergences against the lowest valid channel and captures the first.
module tt_lockstep_checker #(
    parameter int NUM_CH = 3,
    parameter int WIDTH  = 8,
    parameter int WARMUP = 4,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      clear,
    input  logic                      stop_on_err,
    input  logic [NUM_CH-1:0]         ch_valid,
    input  logic [NUM_CH*WIDTH-1:0]   uo_out_ch,
    input  logic [NUM_CH*WIDTH-1:0]   uio_out_ch,
    input  logic [NUM_CH*WIDTH-1:0]   uio_oe_ch,
    output logic                      mismatch,
    output logic                      sticky_err,
    output logic [CNT_W-1:0]          err_count,
    output logic [CNT_W-1:0]          cycle_count,
    output logic [CNT_W-1:0]          first_cycle,
    output logic [2:0]                first_ch,
    output logic [3*WIDTH-1:0]        first_diff,
    output logic [1:0]                state
);

    typedef enum logic [1:0] {
        WARM = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [7:0] WARM_LAST = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);

    state_t st_q, st_d;
    logic [7:0] warm_q, warm_d;

    logic [WIDTH-1:0] uo_a  [NUM_CH];
    logic [WIDTH-1:0] uio_a [NUM_CH];
    logic [WIDTH-1:0] oe_a  [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign uo_a[g]  = uo_out_ch[g*WIDTH +: WIDTH];
        assign uio_a[g] = uio_out_ch[g*WIDTH +: WIDTH];
        assign oe_a[g]  = uio_oe_ch[g*WIDTH +: WIDTH];
    end

    int                 ref_i;
    logic [3:0]         n_valid;
    logic [WIDTH-1:0]   uo_r, uio_r, oe_r;
    logic               hit;
    logic [2:0]         hit_ch;
    logic [3*WIDTH-1:0] hit_diff;
    logic               run_act;
    logic               cmp;
    logic               mm;

    // Descending scan so the lowest valid channel ends up as reference.
    always_comb begin
        ref_i   = 0;
        n_valid = '0;
        uo_r    = '0;
        uio_r   = '0;
        oe_r    = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (ch_valid[c]) begin
                ref_i   = c;
                n_valid = n_valid + 4'd1;
                uo_r    = uo_a[c];
                uio_r   = uio_a[c];
                oe_r    = oe_a[c];
            end
        end
    end

    always_comb begin
        logic [WIDTH-1:0] d_uo, d_uio, d_oe;
        d_uo     = '0;
        d_uio    = '0;
        d_oe     = '0;
        hit      = 1'b0;
        hit_ch   = '0;
        hit_diff = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            d_uo  = uo_a[c] ^ uo_r;
            d_oe  = oe_a[c] ^ oe_r;
            d_uio = (uio_a[c] ^ uio_r) & oe_a[c] & oe_r;
            if (ch_valid[c] && (c != ref_i) && (|{d_uo, d_uio, d_oe})) begin
                hit      = 1'b1;
                hit_ch   = 3'(c);
                hit_diff = {d_uo, d_uio, d_oe};
            end
        end
    end

    // A zero-length warm-up makes the first enabled WARM cycle a compare.
    assign run_act = (st_q == RUN) || ((st_q == WARM) && (WARMUP == 0));
    assign cmp     = ena && !clear && run_act && (n_valid >= 4'd2);
    assign mm      = cmp && hit;

    always_comb begin
        st_d   = st_q;
        warm_d = warm_q;
        if (clear) begin
            st_d   = WARM;
            warm_d = '0;
        end else if (ena) begin
            case (st_q)
                WARM: begin
                    if (warm_q == WARM_LAST) begin
                        st_d = (mm && stop_on_err) ? HALT : RUN;
                    end else begin
                        warm_d = warm_q + 8'd1;
                    end
                end
                RUN: begin
                    if (mm && stop_on_err) st_d = HALT;
                end
                HALT: st_d = HALT;
                default: st_d = WARM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= WARM;
            warm_q      <= '0;
            mismatch    <= 1'b0;
            sticky_err  <= 1'b0;
            err_count   <= '0;
            cycle_count <= '0;
            first_cycle <= '0;
            first_ch    <= '0;
            first_diff  <= '0;
        end else begin
            st_q   <= st_d;
            warm_q <= warm_d;
            if (clear) begin
                mismatch    <= 1'b0;
                sticky_err  <= 1'b0;
                err_count   <= '0;
                cycle_count <= '0;
                first_cycle <= '0;
                first_ch    <= '0;
                first_diff  <= '0;
            end else begin
                mismatch <= mm;
                if (cmp && (cycle_count != '1)) begin
                    cycle_count <= cycle_count + 1'b1;
                end
                if (mm) begin
                    if (err_count != '1) err_count <= err_count + 1'b1;
                    if (!sticky_err) begin
                        sticky_err  <= 1'b1;
                        first_cycle <= cycle_count;
                        first_ch    <= hit_ch;
                        first_diff  <= hit_diff;
                    end
                end
            end
        end
    end

    assign state = st_q;

endmodule

// File: doc/tt_lockstep_checker.md
# tt_lockstep_checker

Parametrised lockstep comparator for the TinyTapeout-style simulation harness. It compares the `uo_out`/`uio_out`/`uio_oe` buses of up to eight design instances that are driven with identical stimulus, once per clock. It counts divergences, captures the first divergence, and can halt on error. It supersedes ad-hoc side-by-side instantiation with a self-checking, synthesizable block usable both in benches and on-chip.

## Interface

Parameters:
- `NUM_CH`, default 3: number of compared channels; legal range 2..8.
- `WIDTH`, default 8: width of each per-channel bus.
- `WARMUP`, default 4: enabled cycles ignored after reset or clear; legal range 0..255.
- `CNT_W`, default 16: width of all counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ena`  in  1  compare enable; when low, all state holds.
- `clear`  in  1  synchronous clear of counters, capture and FSM.
- `stop_on_err`  in  1  when high, the first mismatch moves the FSM to HALT.
- `ch_valid`  in  NUM_CH  per-channel participate mask.
- `uo_out_ch`  in  NUM_CH*WIDTH  packed `uo_out` of each channel; channel c occupies bits [c*WIDTH +: WIDTH].
- `uio_out_ch`  in  NUM_CH*WIDTH  packed `uio_out`, same packing.
- `uio_oe_ch`  in  NUM_CH*WIDTH  packed `uio_oe`, same packing.
- `mismatch`  out  1  registered per-cycle mismatch flag.
- `sticky_err`  out  1  set on the first mismatch; cleared only by reset or `clear`.
- `err_count`  out  CNT_W  count of mismatching cycles; saturates.
- `cycle_count`  out  CNT_W  count of compared cycles; saturates.
- `first_cycle`  out  CNT_W  value of `cycle_count` at the first mismatch.
- `first_ch`  out  3  index of the lowest mismatching channel at the first mismatch.
- `first_diff`  out  3*WIDTH  {uo diff, uio_out diff, oe diff} captured at the first mismatch.
- `state`  out  2  FSM state: WARM=0, RUN=1, HALT=2.

## Operation

- **Reference channel:** the lowest-index channel with `ch_valid` set. Every other valid channel c is compared against it.
- **Per-channel diffs** (combinational):
  - `d_uo = uo_c ^ uo_ref`
  - `d_oe = oe_c ^ oe_ref`
  - `d_uio = (uio_c ^ uio_ref) & oe_c & oe_ref`. Undriven pins are don't-care.
- **Channel mismatch:** any bit set in `d_uo`, `d_uio` or `d_oe`.
- **Comparable cycle:** `ena=1`, no `clear`, FSM in RUN, and at least two channels valid. Otherwise no comparison happens and `cycle_count` does not advance.
- **FSM:**
  - WARM: counts enabled cycles. After `WARMUP` such cycles it moves to RUN. With `WARMUP=0` it enters RUN on the first enabled cycle, and that cycle is compared.
  - RUN: compares every comparable cycle. On a mismatch with `stop_on_err=1` it moves to HALT.
  - HALT: holds all counters and captures; `mismatch`=0. Only `clear` or reset exit HALT, and both go to WARM.
- **First-mismatch capture:** when `sticky_err`=0 and a mismatch occurs, capture `first_cycle` = `cycle_count` before increment, `first_ch`, and `first_diff` of that channel. Then set `sticky_err`. Later mismatches never overwrite the capture.
- **Counters:** saturate at all-ones and never wrap.
  - `cycle_count` increments on every comparable cycle.
  - `err_count` increments on every mismatching cycle (one per cycle, not per channel).
- **Priority:** `clear` overrides `ena`, comparison and the FSM transition in the same cycle.

## Timing

- **Reset values:** all outputs 0; `state`=WARM; warm-up counter 0.
- **Latency:** inputs are sampled at the rising edge. `mismatch`, the counters, the capture and `state` update at that edge and are visible one cycle after the offending inputs. There is no combinational input-to-output path.
- **`mismatch`:** asserted for exactly the cycle following each mismatching sample; deasserted otherwise.
- **`ena`=0:** all registers hold, including the warm-up counter, and `mismatch` goes to 0.
- **`clear` mid-run:** on the next edge all counters, captures and `sticky_err` are 0, and `state`=WARM.
- **Asynchronous reset mid-operation:** outputs go to reset values immediately, independent of `clk`.
- **`ch_valid` changes:** take effect in the same cycle. If the reference channel drops out, the next valid channel becomes the reference.

## Test plan

- **Identical channels:** reset, `ena`=1, `WARMUP`=4, all three channels identical for 20 cycles -> `state` goes to RUN after 4 cycles, `cycle_count`=16, `err_count`=0, `sticky_err`=0.
- **Single bit flip:** in RUN at `cycle_count`=5, channel 2 `uo_out` differs in bit 3 -> next cycle `mismatch`=1, `first_ch`=2, `first_cycle`=5, `first_diff`[uo]=0x08, `err_count`=1.
- **Don't-care masking:** `uio_out` differs on channel 1 while `uio_oe`=0x00 on both channels -> no mismatch. Same difference with `uio_oe`=0xFF -> mismatch, `first_diff`[uio] = the XOR value.
- **Stop on error:** `stop_on_err`=1, inject a mismatch -> `state`=HALT, counters frozen over 10 further cycles. Assert `clear` -> all outputs 0 and `state`=WARM.
- **Saturation:** `CNT_W`=4, mismatch every cycle for 20 cycles -> `err_count` and `cycle_count` hold at 15.
- **Reference dropout:** drop `ch_valid`[0] mid-run -> channel 1 becomes the reference. Drop to one valid channel -> `cycle_count` stops advancing.
